round_timer: RTL and testbench
==============================

// Module: round_timer
// PURPOSE
//  Round countdown timer in MM:SS, kept internally as four BCD digits. Feeds the
//  4-digit seven-segment scanner directly: num3..num0 = min tens, min ones,
//  sec tens, sec ones. Signals round expiry to game control as a one-cycle pulse.
// PARAMETERS
//  TICK_DIV  50_000_000  clk cycles per timer second (>=2); prescaler width = $clog2(TICK_DIV)
//  INIT_MIN  1           load/reset minutes, 0..99
//  INIT_SEC  55          load/reset seconds, 0..59
// PORTS
//  clk      in   1  system clock, all state on posedge
//  rst_n    in   1  asynchronous active-low reset
//  load     in   1  reload INIT value, go IDLE
//  start    in   1  begin/resume countdown
//  hold     in   1  level; freeze countdown while high
//  num3     out  4  minutes tens (BCD)
//  num2     out  4  minutes ones (BCD)
//  num1     out  4  seconds tens (BCD, 0..5)
//  num0     out  4  seconds ones (BCD)
//  running  out  1  high while state == RUN
//  zero     out  1  high while all four digits are 0
//  expired  out  1  one-cycle pulse on reaching 00:00
// BEHAVIOUR
//  - All outputs registered or decoded from registers only; no comb path from inputs.
//  - Reset: state IDLE, digits = INIT_MIN/INIT_SEC in BCD (defaults 0,1,5,5),
//    prescaler 0, running 0, expired 0, zero = (INIT == 00:00).
//  - States: IDLE, RUN, PAUSED, EXPIRED. Per-edge input priority: load > hold > start.
//  - load (any state): next state IDLE, digits = INIT, prescaler 0, expired 0.
//  - IDLE: start=1 and hold=0 -> RUN, prescaler 0. If digits == 00:00 at that edge,
//    go to EXPIRED instead and pulse expired.
//  - RUN: hold=1 -> PAUSED; prescaler and digits frozen from that edge. Else the
//    prescaler increments; at TICK_DIV-1 it wraps to 0 and the time decrements by 1 s
//    on the same edge. start is ignored in RUN.
//  - PAUSED: start=1 and hold=0 -> RUN; prescaler resumes from its frozen value.
//    hold falling alone does not resume.
//  - EXPIRED: digits remain 0000, running 0. Only load leaves this state.
//  - Decrement, BCD with borrow: s0>0 -> s0-1; else s0=9 and borrow into s1.
//    s1 borrow: s1>0 -> s1-1; else s1=5 and borrow into m0.
//    m0 borrow: m0>0 -> m0-1; else m0=9 and m1-1.
//    Example: 10:00 -> 09:59.
//  - Reaching 00:00: on the decrement edge that produces 0000, next state EXPIRED
//    and expired=1 for exactly the following cycle. First expiry occurs TICK_DIV*T
//    cycles after the RUN entry edge, where T is the start time in seconds.
//  - hold and tick on the same edge: hold wins and no decrement occurs.
//  - Digits never leave BCD range. Minutes saturate at 99 (load only); no count-up.
//  - Async reset asserted mid-RUN: immediate return to reset values, no expired pulse.
// TESTING (bench uses TICK_DIV=4)
//  1. Reset with INIT 1:55 -> num3..0 = 0,1,5,5, running 0, zero 0, expired 0.
//  2. INIT 0:02, start -> digits 00:01 after 4 cycles, 00:00 after 8 cycles;
//     expired high exactly 1 cycle; state EXPIRED, running 0.
//  3. Borrow chain: INIT 10:00, start, one tick -> 0,9,5,9; next tick -> 0,9,5,8.
//  4. Pause: start, hold=1 for 10 cycles after 2 prescaler counts; drop hold, pulse
//     start -> next decrement 2 cycles later; no decrement while held.
//  5. Priority: load+start on the same edge -> IDLE with INIT digits.
//     start during EXPIRED -> no change. load during EXPIRED -> IDLE.
//  6. INIT 0:00, start -> EXPIRED on that edge, one expired pulse, zero 1.
//     Assert rst_n=0 mid-RUN -> outputs reset asynchronously.

Source files
------------

// File: rtl/round_timer.sv
// -----------------------------------------------------------------------------
// round_timer
//   Round countdown timer in MM:SS, held internally as four BCD digits that feed
//   a 4-digit seven-segment scanner directly. A one-cycle expired pulse tells
//   game control that the round has reached 00:00.
//
// Ports
//   clk      in   1  system clock, all state on posedge
//   rst_n    in   1  asynchronous active-low reset
//   load     in   1  reload INIT value, go IDLE (highest priority)
//   start    in   1  begin/resume countdown
//   hold     in   1  level; freeze countdown while high
//   num3     out  4  minutes tens (BCD)
//   num2     out  4  minutes ones (BCD)
//   num1     out  4  seconds tens (BCD, 0..5)
//   num0     out  4  seconds ones (BCD)
//   running  out  1  high while state == RUN
//   zero     out  1  high while all four digits are 0
//   expired  out  1  one-cycle pulse on reaching 00:00
// -----------------------------------------------------------------------------
module round_timer #(
    parameter int TICK_DIV = 50_000_000,
    parameter int INIT_MIN = 1,
    parameter int INIT_SEC = 55
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       start,
    input  logic       hold,
    output logic [3:0] num3,
    output logic [3:0] num2,
    output logic [3:0] num1,
    output logic [3:0] num0,
    output logic       running,
    output logic       zero,
    output logic       expired
);

    localparam int            PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRE_ZERO = PW'(0);
    localparam logic [PW-1:0] PRE_ONE  = PW'(1);
    localparam logic [15:0]   INIT_BCD = {4'(INIT_MIN / 10), 4'(INIT_MIN % 10),
                                          4'(INIT_SEC / 10), 4'(INIT_SEC % 10)};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    state_t        state_r, state_nxt_s;
    logic [15:0]   digits_r, digits_nxt_s;
    logic [PW-1:0] presc_r, presc_nxt_s;
    logic          running_r, zero_r, expired_r, expired_nxt_s;

    // One-second BCD decrement of {m1,m0,s1,s0} with borrow rippling upward.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] m1, m0, s1, s0;
        {m1, m0, s1, s0} = t;
        if (s0 != 4'd0) begin
            s0 = s0 - 4'd1;
        end else begin
            s0 = 4'd9;
            if (s1 != 4'd0) begin
                s1 = s1 - 4'd1;
            end else begin
                s1 = 4'd5;
                if (m0 != 4'd0) begin
                    m0 = m0 - 4'd1;
                end else begin
                    m0 = 4'd9;
                    m1 = m1 - 4'd1;
                end
            end
        end
        return {m1, m0, s1, s0};
    endfunction

    // Next-state logic; input priority is load > hold > start.
    always_comb begin
        state_nxt_s   = state_r;
        digits_nxt_s  = digits_r;
        presc_nxt_s   = presc_r;
        expired_nxt_s = 1'b0;
        if (load) begin
            state_nxt_s  = IDLE;
            digits_nxt_s = INIT_BCD;
            presc_nxt_s  = PRE_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!hold && start) begin
                        presc_nxt_s = PRE_ZERO;
                        // Starting at 00:00 expires immediately.
                        if (digits_r == 16'd0) begin
                            state_nxt_s   = EXPIRED;
                            expired_nxt_s = 1'b1;
                        end else begin
                            state_nxt_s = RUN;
                        end
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                RUN: begin
                    if (hold) begin
                        // Hold beats a coincident tick: nothing advances.
                        state_nxt_s = PAUSED;
                    end else if (presc_r == PRE_MAX) begin
                        presc_nxt_s  = PRE_ZERO;
                        digits_nxt_s = bcd_dec(digits_r);
                        if (digits_nxt_s == 16'd0) begin
                            state_nxt_s   = EXPIRED;
                            expired_nxt_s = 1'b1;
                        end else begin
                            state_nxt_s = RUN;
                        end
                    end else begin
                        presc_nxt_s = presc_r + PRE_ONE;
                    end
                end
                PAUSED: begin
                    // Prescaler keeps its frozen value across the resume.
                    if (!hold && start) begin
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s = PAUSED;
                    end
                end
                EXPIRED: begin
                    digits_nxt_s = 16'd0;
                end
                default: begin
                    state_nxt_s  = IDLE;
                    digits_nxt_s = INIT_BCD;
                    presc_nxt_s  = PRE_ZERO;
                end
            endcase
        end
    end

    // State, digit and output registers; status flags come from next-state values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            digits_r  <= INIT_BCD;
            presc_r   <= PRE_ZERO;
            running_r <= 1'b0;
            expired_r <= 1'b0;
            zero_r    <= (INIT_BCD == 16'd0);
        end else begin
            state_r   <= state_nxt_s;
            digits_r  <= digits_nxt_s;
            presc_r   <= presc_nxt_s;
            running_r <= (state_nxt_s == RUN);
            expired_r <= expired_nxt_s;
            zero_r    <= (digits_nxt_s == 16'd0);
        end
    end

    assign {num3, num2, num1, num0} = digits_r;
    assign running = running_r;
    assign zero    = zero_r;
    assign expired = expired_r;

endmodule

// File: tb/tb_round_timer.sv
// -----------------------------------------------------------------------------
// tb_round_timer
//   Directed bench for round_timer with TICK_DIV=4. Four instances with
//   different INIT values share clock, reset and control inputs; each scenario
//   reloads all of them and then checks the instance it targets.
// -----------------------------------------------------------------------------
module tb_round_timer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load = 1'b0;
    logic start = 1'b0;
    logic hold = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [3:0] a3, a2, a1, a0, b3, b2, b1, b0, c3, c2, c1, c0, d3, d2, d1, d0;
    logic       a_run, a_zero, a_exp, b_run, b_zero, b_exp;
    logic       c_run, c_zero, c_exp, d_run, d_zero, d_exp;

    // 10-unit clock period.
    always #5 clk = ~clk;

    round_timer #(.TICK_DIV(4), .INIT_MIN(1), .INIT_SEC(55)) u_a (
        .clk(clk), .rst_n(rst_n), .load(load), .start(start), .hold(hold),
        .num3(a3), .num2(a2), .num1(a1), .num0(a0),
        .running(a_run), .zero(a_zero), .expired(a_exp));

    round_timer #(.TICK_DIV(4), .INIT_MIN(0), .INIT_SEC(2)) u_b (
        .clk(clk), .rst_n(rst_n), .load(load), .start(start), .hold(hold),
        .num3(b3), .num2(b2), .num1(b1), .num0(b0),
        .running(b_run), .zero(b_zero), .expired(b_exp));

    round_timer #(.TICK_DIV(4), .INIT_MIN(10), .INIT_SEC(0)) u_c (
        .clk(clk), .rst_n(rst_n), .load(load), .start(start), .hold(hold),
        .num3(c3), .num2(c2), .num1(c1), .num0(c0),
        .running(c_run), .zero(c_zero), .expired(c_exp));

    round_timer #(.TICK_DIV(4), .INIT_MIN(0), .INIT_SEC(0)) u_d (
        .clk(clk), .rst_n(rst_n), .load(load), .start(start), .hold(hold),
        .num3(d3), .num2(d2), .num1(d1), .num0(d0),
        .running(d_run), .zero(d_zero), .expired(d_exp));

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load();
        load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        // 1. Reset state.
        #12;
        check_val("rst_digits", {a3, a2, a1, a0}, 16'h0155);
        check_val("rst_flags", {13'd0, a_run, a_zero, a_exp}, 16'h0000);
        check_val("rst_zero_init0", {15'd0, d_zero}, 16'h0001);
        rst_n = 1'b1;
        step(1);
        check_val("idle_hold_digits", {a3, a2, a1, a0}, 16'h0155);

        // 2. 0:02 countdown to expiry.
        do_load();
        do_start();
        check_val("b_running", {15'd0, b_run}, 16'h0001);
        step(3);
        check_val("b_before_tick", {b3, b2, b1, b0}, 16'h0002);
        step(1);
        check_val("b_after_4", {b3, b2, b1, b0}, 16'h0001);
        step(3);
        check_val("b_before_2nd", {b3, b2, b1, b0}, 16'h0001);
        step(1);
        check_val("b_after_8", {b3, b2, b1, b0}, 16'h0000);
        check_val("b_exp_pulse", {13'd0, b_run, b_zero, b_exp}, 16'h0003);
        step(1);
        check_val("b_exp_end", {13'd0, b_run, b_zero, b_exp}, 16'h0002);

        // 5. start ignored in EXPIRED, load leaves it, load beats start.
        do_start();
        check_val("b_exp_start", {b3, b2, b1, b0, 1'b0, b_run, b_exp, b_zero}, 16'h0001);
        do_load();
        check_val("b_exp_load", {b3, b2, b1, b0}, 16'h0002);
        check_val("b_exp_load_fl", {13'd0, b_run, b_zero, b_exp}, 16'h0000);
        load = 1'b1;
        start = 1'b1;
        step(1);
        load = 1'b0;
        start = 1'b0;
        step(2);
        check_val("load_start_idle", {15'd0, b_run}, 16'h0000);
        check_val("load_start_dig", {b3, b2, b1, b0}, 16'h0002);

        // 3. Borrow chain 10:00 -> 09:59 -> 09:58.
        do_load();
        do_start();
        step(4);
        check_val("c_borrow", {c3, c2, c1, c0}, 16'h0959);
        step(4);
        check_val("c_borrow2", {c3, c2, c1, c0}, 16'h0958);

        // 4. Pause after two prescaler counts; resume keeps the count.
        do_load();
        do_start();
        step(2);
        hold = 1'b1;
        step(1);
        check_val("c_paused_run", {15'd0, c_run}, 16'h0000);
        step(9);
        check_val("c_held_digits", {c3, c2, c1, c0}, 16'h1000);
        hold = 1'b0;
        step(1);
        check_val("c_hold_fall", {15'd0, c_run}, 16'h0000);
        do_start();
        check_val("c_resumed", {15'd0, c_run}, 16'h0001);
        step(1);
        check_val("c_res_pre", {c3, c2, c1, c0}, 16'h1000);
        step(1);
        check_val("c_res_tick", {c3, c2, c1, c0}, 16'h0959);

        // Hold on the tick edge suppresses the decrement.
        do_load();
        do_start();
        step(3);
        hold = 1'b1;
        step(1);
        check_val("c_hold_tick", {c3, c2, c1, c0}, 16'h1000);
        hold = 1'b0;

        // 6. Start at 00:00 expires on the same edge.
        do_load();
        do_start();
        check_val("d_exp_now", {13'd0, d_run, d_zero, d_exp}, 16'h0003);
        step(1);
        check_val("d_exp_once", {13'd0, d_run, d_zero, d_exp}, 16'h0002);

        // Asynchronous reset in the middle of RUN.
        do_load();
        do_start();
        step(5);
        check_val("a_run_dig", {a3, a2, a1, a0}, 16'h0154);
        check_val("a_run_flag", {15'd0, a_run}, 16'h0001);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("a_async_dig", {a3, a2, a1, a0}, 16'h0155);
        check_val("a_async_fl", {13'd0, a_run, a_zero, a_exp}, 16'h0000);
        step(2);
        rst_n = 1'b1;
        step(2);
        check_val("a_post_rst", {a3, a2, a1, a0, 3'd0, a_run}, 16'h1550);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
